// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared multi-cycle ALU
module alu_arbiter #(
    parameter int MULCYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [2:0]  op0,
    input  logic [2:0]  op1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_res1,
    input  logic [31:0] alu_res2,
    input  logic [3:0]  alu_flags,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic        rsp_err,
    output logic [31:0] rsp_res1,
    output logic [31:0] rsp_res2,
    output logic [3:0]  rsp_flags,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, ERR} state_t;

    localparam logic [3:0] MUL_CNT = 4'(MULCYCLES);

    state_t      state;
    state_t      state_nxt;
    logic        rr;
    logic        owner;
    logic [3:0]  cnt;
    logic        grant;
    logic        win;
    logic [2:0]  win_op;

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                // rr only matters when both requesters compete
                if (req0 && (!req1 || !rr))
                    gnt0 = 1'b1;
                else if (req1)
                    gnt1 = 1'b1;
            end
            default: ;
        endcase
        grant  = gnt0 | gnt1;
        win    = gnt1;
        win_op = win ? op1 : op0;
        case (state)
            IDLE:    if (grant) state_nxt = (win_op == 3'b111) ? ERR : EXEC;
            EXEC:    if (cnt == 4'd1) state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr        <= 1'b0;
            owner     <= 1'b0;
            cnt       <= 4'd0;
            alu_a     <= 32'd0;
            alu_b     <= 32'd0;
            alu_ctrl  <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_res1  <= 32'd0;
            rsp_res2  <= 32'd0;
            rsp_flags <= 4'd0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        alu_ctrl <= win_op;
                        alu_a    <= win ? a1 : a0;
                        alu_b    <= win ? b1 : b0;
                        owner    <= win;
                        rr       <= ~win;
                        cnt      <= win_op[2] ? MUL_CNT : 4'd1;
                    end
                end
                EXEC: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= owner;
                        rsp_err   <= 1'b0;
                        rsp_res1  <= alu_res1;
                        rsp_res2  <= alu_res2;
                        rsp_flags <= alu_flags;
                    end
                end
                ERR: begin
                    // illegal op never reaches the ALU result path
                    rsp_valid <= 1'b1;
                    rsp_id    <= owner;
                    rsp_err   <= 1'b1;
                    rsp_res1  <= 32'd0;
                    rsp_res2  <= 32'd0;
                    rsp_flags <= 4'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [2:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic        gnt0, gnt1;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_res1, alu_res2;
    logic [3:0]  alu_flags;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [31:0] rsp_res1, rsp_res2;
    logic [3:0]  rsp_flags;
    logic        busy;

    int n_checks;
    int n_pass;
    int pulses;

    alu_arbiter #(.MULCYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_res1(alu_res1), .alu_res2(alu_res2), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_res1(rsp_res1), .rsp_res2(rsp_res2), .rsp_flags(rsp_flags),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: flags are {N, Z, C, V}; multiply returns {high, low} signed product
    logic [31:0] bb;
    logic [32:0] sum;
    logic [63:0] prod;
    always_comb begin
        bb        = alu_ctrl[0] ? ~alu_b : alu_b;
        sum       = {1'b0, alu_a} + {1'b0, bb} + {32'd0, alu_ctrl[0]};
        prod      = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});
        alu_res1  = 32'd0;
        alu_res2  = 32'd0;
        alu_flags = 4'd0;
        case (alu_ctrl)
            3'b000, 3'b001: begin
                alu_res1  = sum[31:0];
                alu_flags = {sum[31], sum[31:0] == 32'd0, sum[32],
                             (alu_a[31] == bb[31]) && (sum[31] != alu_a[31])};
            end
            3'b010: begin
                alu_res1  = alu_a & alu_b;
                alu_flags = {alu_res1[31], alu_res1 == 32'd0, 2'b00};
            end
            3'b011: begin
                alu_res1  = alu_a | alu_b;
                alu_flags = {alu_res1[31], alu_res1 == 32'd0, 2'b00};
            end
            default: begin
                alu_res1  = prod[63:32];
                alu_res2  = prod[31:0];
                alu_flags = {prod[63], prod == 64'd0, 2'b00};
            end
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 3'd0; op1 = 3'd0;
        a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
        step; step;
        check("rst_busy", busy, 0);
        check("rst_gnt", {gnt0, gnt1}, 0);
        check("rst_rsp", {rsp_valid, rsp_id, rsp_err, rsp_flags}, 0);
        check("rst_alu", {alu_a, alu_b[28:0], alu_ctrl}, 0);

        // both requesters held from reset: alternate 0,1,0,1
        req0 = 1'b1; req1 = 1'b1;
        op0 = 3'b010; op1 = 3'b010;
        a0 = 32'hF0; b0 = 32'h3C; a1 = 32'hF0; b1 = 32'h3C;
        step;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("rr_gnt", {gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i > 0) begin
                check("rr_valid", rsp_valid, 1);
                check("rr_id", rsp_id, ((i - 1) % 2));
                check("rr_res", rsp_res1, 32'h30);
            end
            step;
            check("rr_exec", {gnt0, gnt1, rsp_valid, busy}, 4'b0001);
            step;
        end
        req0 = 1'b0; req1 = 1'b0;
        #1;
        check("rr_last", {rsp_valid, rsp_id}, 2'b11);
        check("rr_last_res", rsp_res1, 32'h30);

        // single add, operands changed after grant must be ignored
        step;
        req0 = 1'b1; op0 = 3'b000; a0 = 32'd5; b0 = 32'd7;
        #1;
        check("add_gnt", {gnt0, gnt1}, 2'b10);
        step;
        req0 = 1'b0; a0 = 32'd100; b0 = 32'd200;
        #1;
        check("add_busy", {busy, rsp_valid, gnt0}, 3'b100);
        step;
        #1;
        check("add_valid", {rsp_valid, rsp_id, rsp_err}, 3'b100);
        check("add_res", rsp_res1, 32'd12);
        check("add_flags", rsp_flags, 4'b0000);
        step;
        #1;
        check("add_hold", {rsp_valid, rsp_res1}, {1'b0, 32'd12});

        // multiply on requester 1
        req1 = 1'b1; op1 = 3'b110; a1 = 32'hFFFFFFFF; b1 = 32'd3;
        #1;
        check("mul_gnt", {gnt0, gnt1}, 2'b01);
        step;
        req1 = 1'b0;
        #1;
        check("mul_busy1", {busy, rsp_valid}, 2'b10);
        check("mul_ctrl", alu_ctrl, 3'b110);
        step;
        #1;
        check("mul_busy2", {busy, rsp_valid}, 2'b10);
        step;
        #1;
        check("mul_valid", {rsp_valid, rsp_id, rsp_err, busy}, 4'b1100);
        check("mul_res", {rsp_res1, rsp_res2}, 64'hFFFFFFFF_FFFFFFFD);

        // illegal op
        step;
        req0 = 1'b1; op0 = 3'b111; a0 = 32'd9; b0 = 32'd9;
        #1;
        check("err_gnt", {gnt0, gnt1}, 2'b10);
        step;
        req0 = 1'b0;
        #1;
        check("err_busy", {busy, rsp_valid}, 2'b10);
        step;
        #1;
        check("err_valid", {rsp_valid, rsp_id, rsp_err, busy}, 4'b1010);
        check("err_res", {rsp_res1, rsp_res2, rsp_flags}, 0);

        // subtract passes through unchanged
        step;
        req0 = 1'b1; op0 = 3'b001; a0 = 32'd3; b0 = 32'd3;
        #1;
        check("sub_gnt", {gnt0, gnt1}, 2'b10);
        step;
        req0 = 1'b0;
        #1;
        check("sub_ctrl", alu_ctrl, 3'b001);
        step;
        #1;
        check("sub_valid", {rsp_valid, rsp_err}, 2'b10);
        check("sub_res", rsp_res1, 32'd0);
        check("sub_flags", rsp_flags, 4'b0110);

        // reset mid-multiply discards the op
        step;
        req0 = 1'b1; op0 = 3'b101; a0 = 32'd2; b0 = 32'd4;
        #1;
        check("rm_gnt", {gnt0, gnt1}, 2'b10);
        step;
        req0 = 1'b0;
        #1;
        check("rm_pre", {busy, alu_a}, {1'b1, 32'd2});
        reset = 1'b1;
        #1;
        check("rm_async_alu", {alu_a, alu_b, alu_ctrl}, 0);
        check("rm_async_rsp", {rsp_valid, rsp_id, rsp_err, rsp_res1, rsp_res2, rsp_flags}, 0);
        check("rm_async_st", {busy, gnt0, gnt1}, 0);
        step;
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (rsp_valid) pulses++;
            step;
        end
        check("rm_no_pulse", pulses, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
